dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Responder side of the per-core data-memory interface for the 4-core multiplier processor.
- Accepts read and write requests from up to four cores over a req/ack handshake.
- Arbitrates them round-robin onto one single-port data RAM held inside the block.
- Returns an ack, plus read data for reads. Replaces direct multi-ported access so the data memory maps onto one FPGA block-RAM port.

Parameters:
- NPORT, 4, number of requesting cores (fixed at 4 for this revision).
- AW, 8, address width; RAM depth is 2^AW words.
- DW, 8, data word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NPORT  per-port request; held high until that port's ack.
- we  input  NPORT  per-port write enable, qualified by req (1 = write, 0 = read).
- addr  input  NPORT*AW  packed addresses; port k is bits [k*AW +: AW].
- wdata  input  NPORT*DW  packed write data; port k is bits [k*DW +: DW].
- ack  output  NPORT  one-hot, one-cycle completion pulse.
- rdata  output  DW  read data; valid in the cycle the matching ack is high for a read.
- stall_cnt  output  16  saturating count of cycles with at least one request left waiting.

Behaviour:
- Reset (rst_n low at a rising edge):
  - ack=0, rdata=0, stall_cnt=0; round-robin pointer rr=0, so port 0 has highest priority.
  - In-flight marker cleared.
  - RAM contents are not cleared. No RAM write occurs on a reset edge.
- Requester contract:
  - we, addr and wdata stay stable while req is high and ack has not been seen.
  - The requester may deassert req in the ack cycle, or keep it high to issue a new request.
  - The new request must present the next values from the ack cycle onward.
- Eligibility in cycle N: port k is eligible if req[k]=1 and ack[k]=0 in cycle N. A port in its ack cycle is masked, so a held req is not double-granted.
- Arbitration is combinational over eligible ports.
  - Search order is rr, rr+1, ..., wrapping modulo NPORT.
  - The first eligible port g wins.
- Access at the rising edge ending cycle N, for winner g:
  - Write: RAM[addr_g] <= wdata_g.
  - Read: rdata <= RAM[addr_g].
  - In both cases ack <= one-hot(g) and rr <= (g+1) mod NPORT.
- No eligible port: ack <= 0, rr unchanged, rdata holds its last value.
- Latency and throughput:
  - Request seen in cycle N with no contention: ack and rdata in cycle N+1.
  - One access per cycle aggregate.
  - A single port can complete at most every second cycle.
- Ordering: accesses are serialised in grant order. A read granted after a write to the same address returns the new data, including when the read is granted in the very next cycle.
- rdata after a write ack is unspecified but stable; it holds the previous value.
- stall_cnt: increments when (number of eligible ports) > 1 in a cycle; saturates at 16'hFFFF; never wraps.
- Requests in the reset cycle:
  - No grant is made.
  - Requests held high are arbitrated normally from the first cycle with rst_n=1, starting at rr=0.
- Reset during an in-flight ack cycle: ack is forced to 0 next cycle. A write already committed at an earlier edge remains in RAM.
- Changing we/addr/wdata mid-request violates the contract; the RAM is still never written with X-merged partial data beyond the sampled values.

Test Plan:
- Single write, then read:
  - Port 0 writes addr 8'h10 = 8'hA5, then reads 8'h10.
  - Required: ack=4'b0001 one cycle after each request; read returns rdata=8'hA5.
- Four simultaneous reads after rst_n release:
  - Preload: addr 8'h00..8'h03 = 8'h11, 8'h22, 8'h33, 8'h44.
  - Ports 0..3 request reads of 8'h00..8'h03 together, each dropping req on its ack.
  - Required: acks in cycles 1..4 as 0001, 0010, 0100, 1000, with rdata 8'h11, 8'h22, 8'h33, 8'h44; stall_cnt=3.
- Round-robin fairness:
  - Ports 1 and 3 hold req continuously for 8 cycles.
  - Required: grants alternate 1, 3, 1, 3; no port is acked on consecutive cycles; port 0 is never acked.
- Write/read hazard:
  - Port 2 writes 8'h7F = 8'h5C; port 3 requests a read of 8'h7F in the same cycle. Port 2 wins, since rr=0 and no higher-priority port is eligible.
  - Required: port 3's ack comes one cycle later with rdata=8'h5C.
- Reset mid-operation:
  - Assert rst_n=0 in the cycle ack=0100 is high while ports 0 and 1 are pending.
  - Required: next cycle ack=0, stall_cnt=0. After release, port 0 is granted first. A write committed before reset reads back intact.
- Saturation:
  - Keep 2+ eligible ports for 70000 cycles.
  - Required: stall_cnt stops at 16'hFFFF and holds there.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter that serialises per-core read/write requests onto one
// single-port data RAM, returning a one-cycle ack (and read data) per access.
module dm_port_arbiter #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] wdata,
    output logic [NPORT-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic [15:0]         stall_cnt
);

    localparam int unsigned PW = $clog2(NPORT);

    logic [DW-1:0] mem [2**AW];

    logic [NPORT-1:0] ack_q, ack_d;
    logic [DW-1:0]    rdata_q;
    logic [PW-1:0]    rr_q;
    logic [15:0]      stall_q;

    logic [NPORT-1:0] eligible;
    logic             gnt_vld;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    idx;
    logic [PW:0]      n_elig;
    logic             gnt_we;
    logic [AW-1:0]    gnt_addr;
    logic [DW-1:0]    gnt_wdata;
    logic [PW-1:0]    rr_next;

    // A port in its ack cycle is masked so a held req is not granted twice.
    assign eligible = req & ~ack_q;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        idx     = '0;
        n_elig  = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx    = PW'((int'(rr_q) + i) % NPORT);
            n_elig = n_elig + (PW+1)'(eligible[i]);
            if (!gnt_vld && eligible[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        gnt_we    = we[gnt_idx];
        gnt_addr  = addr[gnt_idx*AW +: AW];
        gnt_wdata = wdata[gnt_idx*DW +: DW];
        rr_next   = PW'((int'(gnt_idx) + 1) % NPORT);
        ack_d     = '0;
        if (gnt_vld) begin
            ack_d[gnt_idx] = 1'b1;
        end
    end

    // RAM has no reset; writes are suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && gnt_vld && gnt_we) begin
            mem[gnt_addr] <= gnt_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q   <= '0;
            rdata_q <= '0;
            rr_q    <= '0;
            stall_q <= '0;
        end else begin
            ack_q <= ack_d;
            if (gnt_vld) begin
                rr_q <= rr_next;
                if (!gnt_we) begin
                    rdata_q <= mem[gnt_addr];
                end
            end
            if (n_elig > (PW+1)'(1) && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: hand-computed acks, read data and
// stall counts for each scenario, including counter saturation.
module tb_dm_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic [15:0] stall_cnt;

    int vectors;
    int miscompares;

    dm_port_arbiter #(
        .NPORT (4),
        .AW    (8),
        .DW    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [7:0] a,
                            input logic [7:0] d);
        we[p]          = w;
        addr[p*8 +: 8]  = a;
        wdata[p*8 +: 8] = d;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        check("reset_ack", 16'(ack), 16'h0);
        check("reset_rdata", 16'(rdata), 16'h0);
        check("reset_stall", stall_cnt, 16'h0);
        rst_n = 1'b1;

        // Single write then read on port 0.
        set_port(0, 1'b1, 8'h10, 8'hA5);
        req = 4'b0001;
        step();
        check("wr_ack", 16'(ack), 16'h1);
        req = 4'b0000;
        step();
        check("wr_ack_drop", 16'(ack), 16'h0);
        set_port(0, 1'b0, 8'h10, 8'h00);
        req = 4'b0001;
        step();
        check("rd_ack", 16'(ack), 16'h1);
        check("rd_data", 16'(rdata), 16'h00A5);
        req = 4'b0000;
        step();

        // Preload 0x00..0x03 with 0x11..0x44.
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 8'(i), 8'(8'h11 * (i + 1)));
            req = 4'b0001;
            step();
            req = 4'b0000;
            step();
        end

        // Four reads held through reset, arbitrated from the first released cycle.
        for (int k = 0; k < 4; k++) set_port(k, 1'b0, 8'(k), 8'h00);
        req   = 4'b1111;
        rst_n = 1'b0;
        step();
        check("rst_no_grant", 16'(ack), 16'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("quad_ack%0d", k), 16'(ack), 16'(4'b0001 << k));
            check($sformatf("quad_rdata%0d", k), 16'(rdata), 16'(8'h11 * (k + 1)));
            req[k] = 1'b0;
        end
        check("quad_stall", stall_cnt, 16'd3);
        step();
        check("quad_idle", 16'(ack), 16'h0);

        // Ports 1 and 3 held: grants must alternate.
        set_port(1, 1'b0, 8'h01, 8'h00);
        set_port(3, 1'b0, 8'h03, 8'h00);
        req = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_ack%0d", i), 16'(ack), (i % 2 == 0) ? 16'h2 : 16'h8);
        end
        req = 4'b0000;
        step();
        check("rr_idle", 16'(ack), 16'h0);
        check("rr_stall", stall_cnt, 16'd4);

        // Write/read hazard on 0x7F.
        set_port(2, 1'b1, 8'h7F, 8'h5C);
        set_port(3, 1'b0, 8'h7F, 8'h00);
        req = 4'b1100;
        step();
        check("haz_wr_ack", 16'(ack), 16'h4);
        req[2] = 1'b0;
        step();
        check("haz_rd_ack", 16'(ack), 16'h8);
        check("haz_rd_data", 16'(rdata), 16'h005C);
        req = 4'b0000;
        step();
        check("haz_idle", 16'(ack), 16'h0);
        check("haz_stall", stall_cnt, 16'd5);

        // Reset asserted during port 2's write ack with ports 0 and 1 pending.
        set_port(2, 1'b1, 8'h20, 8'h99);
        req = 4'b0100;
        step();
        check("mid_wr_ack", 16'(ack), 16'h4);
        set_port(0, 1'b0, 8'h20, 8'h00);
        set_port(1, 1'b0, 8'h20, 8'h00);
        req   = 4'b0011;
        rst_n = 1'b0;
        step();
        check("mid_rst_ack", 16'(ack), 16'h0);
        check("mid_rst_stall", stall_cnt, 16'h0);
        check("mid_rst_rdata", 16'(rdata), 16'h0);
        rst_n = 1'b1;
        step();
        check("mid_p0_ack", 16'(ack), 16'h1);
        check("mid_p0_data", 16'(rdata), 16'h0099);
        req[0] = 1'b0;
        step();
        check("mid_p1_ack", 16'(ack), 16'h2);
        check("mid_p1_data", 16'(rdata), 16'h0099);
        req = 4'b0000;
        step();
        check("mid_stall", stall_cnt, 16'd1);

        // Three ports held keep two eligible every cycle until saturation.
        for (int k = 0; k < 3; k++) set_port(k, 1'b0, 8'(k), 8'h00);
        req   = 4'b0111;
        rst_n = 1'b0;
        step();
        check("sat_rst_ack", 16'(ack), 16'h0);
        check("sat_rst_stall", stall_cnt, 16'h0);
        rst_n = 1'b1;
        for (int n = 1; n <= 65635; n++) begin
            step();
            if (n == 1000)  check("sat_1000", stall_cnt, 16'd1000);
            if (n == 65534) check("sat_fffe", stall_cnt, 16'hFFFE);
            if (n == 65535) check("sat_ffff", stall_cnt, 16'hFFFF);
            if (n == 65635) check("sat_hold", stall_cnt, 16'hFFFF);
        end
        req = 4'b0000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
